// File: rtl/key_filter.sv
`default_nettype none
// ============================================================================
//  Module      : key_filter
//  Description : Push-button debouncer for an active-low key. The raw pin is
//                brought into the sys_clk domain through a two-flop
//                synchroniser. A saturating counter then measures how long the
//                synchronised level has stayed low. A single-cycle key_flag
//                pulse is issued once that low level has been stable for
//                CNT_MAX clock cycles.
//  Ports       : sys_clk   - system clock, all logic on rising edge
//                sys_rst_n - asynchronous active-low reset
//                key_in    - raw, bouncy button level (1 = released)
//                key_flag  - one-cycle pulse marking a debounced press
//  Revision    : 1.0 - initial release
// ============================================================================
module key_filter #(
    parameter logic [19:0] CNT_MAX = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic key_flag
);

    logic        key_s1_q;
    logic        key_s_q;
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        key_flag_q;
    logic        key_flag_d;

    // Synchroniser flops reset to the released level so that a key held
    // down through reset is seen as a fresh press after reset deasserts.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1_q <= 1'b1;
            key_s_q  <= 1'b1;
        end else begin
            key_s1_q <= key_in;
            key_s_q  <= key_s1_q;
        end
    end

    // The counter saturates at CNT_MAX instead of wrapping, so a key held
    // indefinitely never reaches CNT_MAX-1 a second time and never re-fires.
    // The flag fires on the single transition CNT_MAX-1 -> CNT_MAX.
    always_comb begin
        cnt_d      = cnt_q;
        key_flag_d = 1'b0;
        if (key_s_q) begin
            cnt_d = 20'd0;
        end else begin
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + 20'd1;
            end
            if (cnt_q == (CNT_MAX - 20'd1)) begin
                key_flag_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q      <= 20'd0;
            key_flag_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            key_flag_q <= key_flag_d;
        end
    end

    assign key_flag = key_flag_q;

endmodule
`default_nettype wire

// File: tb/tb_key_filter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_filter
//  Description : Self-checking bench for key_filter with CNT_MAX = 24.
//                A reference model tracks the length of the current low run
//                of the key as seen two edges late (synchroniser delay) and
//                predicts key_flag and the internal count every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_filter;

    localparam int CNT = 24;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_in    = 1'b1;
    logic key_flag;

    key_filter #(.CNT_MAX(20'd24)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_in),
        .key_flag  (key_flag)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        int low_len;
        int exp_pulses;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    bit samp[$];
    int run      = 0;
    int pulses   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        samp.delete();
        samp.push_back(1'b1);
        samp.push_back(1'b1);
        run = 0;
    endtask

    // One clock cycle: drive the key, let an edge happen, predict and check.
    task automatic cycle(input bit k);
        bit ks;
        key_in = k;
        @(posedge sys_clk);
        samp.push_back(k);
        ks  = samp.pop_front();
        run = ks ? 0 : run + 1;
        #1;
        chk("key_flag", int'(key_flag), (run == CNT) ? 1 : 0);
        chk("cnt", int'(dut.cnt_q), (run > CNT) ? CNT : run);
        if (key_flag) pulses++;
    endtask

    // Asynchronous reset applied at the current (non-edge) time.
    task automatic apply_reset(input int ncyc, input bit k);
        sys_rst_n = 1'b0;
        key_in    = k;
        #1;
        chk("rst_flag_async", int'(key_flag), 0);
        chk("rst_cnt_async", int'(dut.cnt_q), 0);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge sys_clk);
            #1;
            chk("rst_flag_hold", int'(key_flag), 0);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    vec_t vecs[6];
    int   first;
    int   pos;

    initial begin
        vecs[0] = '{low_len: 1,   exp_pulses: 0};
        vecs[1] = '{low_len: 5,   exp_pulses: 0};
        vecs[2] = '{low_len: 23,  exp_pulses: 0};
        vecs[3] = '{low_len: 24,  exp_pulses: 1};
        vecs[4] = '{low_len: 25,  exp_pulses: 1};
        vecs[5] = '{low_len: 100, exp_pulses: 1};

        // 1: key low throughout reset, then held low.
        apply_reset(5, 1'b0);
        pulses = 0;
        first  = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle(1'b0);
            if (key_flag && first == 0) first = e;
        end
        chk("t1_first_pulse_edge", first, CNT + 2);
        chk("t1_pulse_count", pulses, 1);

        repeat (30) cycle(1'b1);

        // Table: a low run of given length, then released.
        foreach (vecs[v]) begin
            pulses = 0;
            for (int i = 0; i < vecs[v].low_len; i++) cycle(1'b0);
            repeat (30) cycle(1'b1);
            chk($sformatf("tbl_low%0d_pulses", vecs[v].low_len), pulses, vecs[v].exp_pulses);
        end

        // 2: framed press with random bounce on both edges.
        for (int f = 0; f < 4; f++) begin
            pulses = 0;
            pos    = -1;
            for (int i = 0; i < 250; i++) begin
                bit k;
                if (i < 19 || i >= 200)      k = 1'b1;
                else if (i >= 70 && i < 150) k = 1'b0;
                else if (i % 16 == 0)        k = 1'b1;
                else                         k = 1'($urandom_range(0, 1));
                cycle(k);
                if (key_flag && pos < 0) pos = i;
            end
            chk("frame_pulses", pulses, 1);
            chk("frame_pulse_in_window", (pos >= 70 && pos <= 152) ? 1 : 0, 1);
        end

        // 3: two 23-cycle lows split by a single high sample.
        pulses = 0;
        repeat (23) cycle(1'b0);
        cycle(1'b1);
        repeat (23) cycle(1'b0);
        repeat (30) cycle(1'b1);
        chk("t3_pulses", pulses, 0);

        // 4: held low for 1000 cycles.
        pulses = 0;
        repeat (1000) cycle(1'b0);
        chk("t4_pulses", pulses, 1);
        chk("t4_cnt_saturated", int'(dut.cnt_q), CNT);
        repeat (30) cycle(1'b1);

        // 5: reset mid-count with key still low.
        pulses = 0;
        repeat (12) cycle(1'b0);
        chk("t5_cnt_before_reset", int'(dut.cnt_q), 10);
        #3;
        apply_reset(3, 1'b0);
        chk("t5_pulses_before_release", pulses, 0);
        first = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle(1'b0);
            if (key_flag && first == 0) first = e;
        end
        chk("t5_first_pulse_edge", first, CNT + 2);
        chk("t5_pulses", pulses, 1);

        // 6: key released for a long time.
        pulses = 0;
        repeat (10000) cycle(1'b1);
        chk("t6_pulses", pulses, 0);
        chk("t6_cnt", int'(dut.cnt_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
